// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the prio_enc_arb priority encoder/arbiter.
package prio_enc_pkg;

  typedef enum logic {IDLE, HOLD} penc_state_e;

  localparam int POP_MAXW = 256;

  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clearing the lowest set bit leaves something behind only if two or more were set.
  function automatic logic popcount_ge2(input logic [POP_MAXW-1:0] v);
    return |(v & (v - POP_MAXW'(1)));
  endfunction

endpackage

// File: rtl/prio_enc_find.sv
// Combinational search: highest set bit starting at start_i and moving downward,
// wrapping from bit 0 to bit N-1. Built as rotate, fixed search, then un-rotate.
module prio_enc_find
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = safe_clog2(N)
) (
  input  logic [N-1:0] din_i,
  input  logic [W-1:0] start_i,
  output logic         hit_o,
  output logic [W-1:0] pos_o
);

  logic [N-1:0] rot;
  int           off;

  function automatic logic [W-1:0] wrap_sub(input logic [W-1:0] a, input int b);
    int t;
    t = int'(a) - b;
    if (t < 0) t = t + N;
    return W'(t);
  endfunction

  // rot[N-1] holds din at start_i, rot[N-2] the next bit down, and so on.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[N-1-k] = din_i[wrap_sub(start_i, k)];
    end
  end

  always_comb begin
    hit_o = 1'b0;
    off   = 0;
    for (int r = 0; r < N; r++) begin
      if (rot[r]) begin
        hit_o = 1'b1;
        off   = N - 1 - r;
      end
    end
    pos_o = wrap_sub(start_i, off);
  end

endmodule

// File: rtl/prio_enc_arb.sv
// N-input priority encoder with fixed/round-robin search and valid/ready output.
// Optional dout_onehot output enabled by PRIO_ENC_ARB_ONEHOT_EN.
module prio_enc_arb
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = safe_clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         mode_rr,
  input  logic         dout_ready,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         dout_multi
`ifdef PRIO_ENC_ARB_ONEHOT_EN
  ,
  output logic [N-1:0] dout_onehot
`endif
);

  localparam logic [W-1:0] TOP = W'(N - 1);

  penc_state_e  state_q, state_d;
  logic [W-1:0] dout_q, dout_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         multi_q, multi_d;
  logic         rr_q, rr_d;
  logic [W-1:0] held_pos, ptr_nxt, start, pos;
  logic         hit, accept;

  assign accept   = (state_q == HOLD) && dout_ready;
  assign held_pos = TOP - dout_q;
  assign ptr_nxt  = (held_pos == '0) ? TOP : held_pos - W'(1);

  // A back-to-back RR capture searches from the pointer implied by the result
  // being handed off, so a constant request vector rotates with no repeats.
  assign start = !mode_rr ? TOP : ((accept && rr_q) ? ptr_nxt : ptr_q);

  prio_enc_find #(.N(N), .W(W)) u_find (
    .din_i   (din),
    .start_i (start),
    .hit_o   (hit),
    .pos_o   (pos)
  );

`ifdef PRIO_ENC_ARB_ONEHOT_EN
  logic [N-1:0] onehot_q, onehot_d;
  assign dout_onehot = onehot_q;
`endif

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    multi_d = multi_q;
    rr_d    = rr_q;
    ptr_d   = ptr_q;
`ifdef PRIO_ENC_ARB_ONEHOT_EN
    onehot_d = onehot_q;
`endif
    if (accept && rr_q) ptr_d = ptr_nxt;
    if (state_q == IDLE || dout_ready) begin
      if (hit) begin
        state_d = HOLD;
        dout_d  = TOP - pos;
        multi_d = popcount_ge2(POP_MAXW'(din));
        rr_d    = mode_rr;
`ifdef PRIO_ENC_ARB_ONEHOT_EN
        onehot_d = {{(N-1){1'b0}}, 1'b1} << pos;
`endif
      end else begin
        state_d = IDLE;
`ifdef PRIO_ENC_ARB_ONEHOT_EN
        onehot_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dout_q  <= '0;
      multi_q <= 1'b0;
      rr_q    <= 1'b0;
      ptr_q   <= TOP;
`ifdef PRIO_ENC_ARB_ONEHOT_EN
      onehot_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      multi_q <= multi_d;
      rr_q    <= rr_d;
      ptr_q   <= ptr_d;
`ifdef PRIO_ENC_ARB_ONEHOT_EN
      onehot_q <= onehot_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == HOLD);
  assign dout_multi = multi_q;

endmodule
